// File: rtl/sys_pkg.sv
// Shared definitions for the UART command sequencer.
// Command codes, operand register addresses and FSM states.
package sys_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int ADDR_OP_A = 0;
  localparam int ADDR_OP_B = 1;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    ALU_A,
    ALU_B,
    ALU_FUN,
    ALU_WAIT,
    TX_RD,
    TX_LSB,
    TX_MSB
  } state_e;

endpackage

// File: rtl/sys_ctrl.sv
// Command sequencer: parses RX frames, drives regfile/ALU,
// and pushes response bytes into the TX FIFO.
module sys_ctrl
  import sys_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  output logic                    WrEn,
  output logic                    RdEn,
  output logic [ADDR_WIDTH-1:0]   Address,
  output logic [DATA_WIDTH-1:0]   WrData,
  input  logic [DATA_WIDTH-1:0]   RdData,
  input  logic                    RdData_Valid,
  output logic                    ALU_EN,
  output logic [3:0]              ALU_FUN,
  output logic                    CLK_EN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    OUT_Valid,
  output logic [DATA_WIDTH-1:0]   WR_DATA,
  output logic                    WR_INC,
  input  logic                    FIFO_FULL
);

  localparam int RW = 2 * DATA_WIDTH;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [RW-1:0]           res_q, res_d;
  logic                    wren_q, wren_d;
  logic                    rden_q, rden_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    alu_en_q, alu_en_d;
  logic [3:0]              fun_q, fun_d;
  logic                    clk_en_q, clk_en_d;
  logic [DATA_WIDTH-1:0]   txd_q, txd_d;
  logic                    inc_q, inc_d;

  // WR_DATA and ALU_FUN states are package-qualified:
  // the port names of the same spelling shadow them here.
  always_comb begin
    state_d  = state_q;
    waddr_d  = waddr_q;
    res_d    = res_q;
    wren_d   = 1'b0;
    rden_d   = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    alu_en_d = 1'b0;
    fun_d    = fun_q;
    txd_d    = txd_q;
    inc_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (RX_D_VLD) begin
          case (RX_P_DATA)
            CMD_WR:      state_d = WR_ADDR;
            CMD_RD:      state_d = RD_ADDR;
            CMD_ALU_OP:  state_d = ALU_A;
            CMD_ALU_NOP: state_d = sys_pkg::ALU_FUN;
            default:     state_d = IDLE;
          endcase
        end
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          waddr_d = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d = sys_pkg::WR_DATA;
        end
      end
      sys_pkg::WR_DATA: begin
        if (RX_D_VLD) begin
          wren_d  = 1'b1;
          addr_d  = waddr_q;
          wdata_d = RX_P_DATA;
          state_d = IDLE;
        end
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          rden_d  = 1'b1;
          addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (RdData_Valid) begin
          res_d   = {{DATA_WIDTH{1'b0}}, RdData};
          state_d = TX_RD;
          // Push straight away when the FIFO has room
          if (!FIFO_FULL) begin
            inc_d   = 1'b1;
            txd_d   = RdData;
            state_d = IDLE;
          end
        end
      end
      ALU_A: begin
        if (RX_D_VLD) begin
          wren_d  = 1'b1;
          addr_d  = ADDR_WIDTH'(ADDR_OP_A);
          wdata_d = RX_P_DATA;
          state_d = ALU_B;
        end
      end
      ALU_B: begin
        if (RX_D_VLD) begin
          wren_d  = 1'b1;
          addr_d  = ADDR_WIDTH'(ADDR_OP_B);
          wdata_d = RX_P_DATA;
          state_d = sys_pkg::ALU_FUN;
        end
      end
      sys_pkg::ALU_FUN: begin
        if (RX_D_VLD) begin
          fun_d    = RX_P_DATA[3:0];
          alu_en_d = 1'b1;
          state_d  = ALU_WAIT;
        end
      end
      ALU_WAIT: begin
        alu_en_d = 1'b1;
        if (OUT_Valid) begin
          alu_en_d = 1'b0;
          res_d    = ALU_OUT;
          state_d  = TX_LSB;
          if (!FIFO_FULL) begin
            inc_d   = 1'b1;
            txd_d   = ALU_OUT[DATA_WIDTH-1:0];
            state_d = TX_MSB;
          end
        end
      end
      TX_RD: begin
        if (!FIFO_FULL) begin
          inc_d   = 1'b1;
          txd_d   = res_q[DATA_WIDTH-1:0];
          state_d = IDLE;
        end
      end
      TX_LSB: begin
        if (!FIFO_FULL) begin
          inc_d   = 1'b1;
          txd_d   = res_q[DATA_WIDTH-1:0];
          state_d = TX_MSB;
        end
      end
      TX_MSB: begin
        if (!FIFO_FULL) begin
          inc_d   = 1'b1;
          txd_d   = res_q[RW-1:DATA_WIDTH];
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    clk_en_d = (state_d == ALU_A) || (state_d == ALU_B) ||
               (state_d == sys_pkg::ALU_FUN) ||
               (state_d == ALU_WAIT);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      waddr_q  <= '0;
      res_q    <= '0;
      wren_q   <= 1'b0;
      rden_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      alu_en_q <= 1'b0;
      fun_q    <= '0;
      clk_en_q <= 1'b0;
      txd_q    <= '0;
      inc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      waddr_q  <= waddr_d;
      res_q    <= res_d;
      wren_q   <= wren_d;
      rden_q   <= rden_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      alu_en_q <= alu_en_d;
      fun_q    <= fun_d;
      clk_en_q <= clk_en_d;
      txd_q    <= txd_d;
      inc_q    <= inc_d;
    end
  end

  assign WrEn    = wren_q;
  assign RdEn    = rden_q;
  assign Address = addr_q;
  assign WrData  = wdata_q;
  assign ALU_EN  = alu_en_q;
  assign ALU_FUN = fun_q;
  assign CLK_EN  = clk_en_q;
  assign WR_DATA = txd_q;
  assign WR_INC  = inc_q;

endmodule

// File: doc/sys_ctrl.md
# sys_ctrl

Single-clock command sequencer between the UART receive/transmit path and the register file and ALU. It parses byte frames delivered by the UART receiver, performs register writes, register reads and ALU operations, and queues response bytes into the TX FIFO that feeds the UART transmitter. It runs in the reference clock domain. RX bytes arrive already synchronised as a one-cycle valid pulse; TX bytes leave through a FIFO write port.

## Interface
- DATA_WIDTH, 8, width of UART bytes, register data and ALU operands
- ADDR_WIDTH, 4, register file address width
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-high reset
- RX_P_DATA  in  DATA_WIDTH  received byte
- RX_D_VLD  in  1  one-cycle pulse, RX_P_DATA valid
- WrEn  out  1  register file write strobe
- RdEn  out  1  register file read strobe
- Address  out  ADDR_WIDTH  register file address
- WrData  out  DATA_WIDTH  register file write data
- RdData  in  DATA_WIDTH  register file read data
- RdData_Valid  in  1  RdData valid, one-cycle pulse
- ALU_EN  out  1  ALU operation enable
- ALU_FUN  out  4  ALU function code
- CLK_EN  out  1  ALU clock-gate enable
- ALU_OUT  in  2*DATA_WIDTH  ALU result
- OUT_Valid  in  1  ALU_OUT valid, one-cycle pulse
- WR_DATA  out  DATA_WIDTH  TX FIFO write data
- WR_INC  out  1  TX FIFO push strobe
- FIFO_FULL  in  1  TX FIFO full

## Operation
- Frame commands, each identified by its first byte:
  - 0xAA = write: addr, data
  - 0xBB = read: addr
  - 0xCC = ALU with operands: A, B, fun
  - 0xDD = ALU without operands: fun
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_RD, TX_LSB, TX_MSB.
- IDLE: a byte not matching a command code is dropped and the state stays IDLE.
- Write: the addr byte is latched (low ADDR_WIDTH bits). On the data byte, WrEn is pulsed with Address and WrData. Return to IDLE.
- Read: on the addr byte, RdEn is pulsed and the block moves to RD_WAIT. On RdData_Valid, RdData is latched and the block moves to TX_RD, which pushes one byte. Return to IDLE.
- ALU with operands:
  - Operand A is written to address 0 and operand B to address 1, each with a WrEn pulse.
  - On the fun byte, ALU_FUN is set to fun[3:0] and the block enters ALU_WAIT.
- ALU without operands: goes directly to ALU_FUN from IDLE.
- ALU_WAIT:
  - ALU_EN is held high until OUT_Valid.
  - On OUT_Valid, ALU_OUT is latched, then TX_LSB pushes the low byte and TX_MSB pushes the high byte.
- CLK_EN is high in ALU_A, ALU_B, ALU_FUN and ALU_WAIT, and low elsewhere.
- Bytes arriving in RD_WAIT, ALU_WAIT or any TX state are dropped. No queueing.

## Timing
- All outputs are registered. Reset value of every output is 0. State resets to IDLE.
- WrEn and RdEn are one-cycle pulses in the cycle after the RX_D_VLD that triggers them. Address and WrData are stable in that same cycle.
- ALU_EN rises in the cycle after the fun byte is accepted. It falls in the cycle after OUT_Valid. ALU_FUN holds until the next fun byte.
- TX states:
  - WR_INC is asserted for exactly one cycle per byte, only when FIFO_FULL = 0.
  - While FIFO_FULL = 1 the FSM holds its state, with WR_INC = 0 and WR_DATA held.
- Latencies with the FIFO not full:
  - Read: RdData_Valid to WR_INC is 1 cycle.
  - ALU: OUT_Valid to LSB push is 1 cycle, and the MSB push follows on the next cycle.
- RdData_Valid or OUT_Valid arriving outside its wait state is ignored.
- RST asserted mid-frame aborts immediately: partial frame discarded, strobes deasserted, no FIFO push.

## Structure
- Shared package sys_pkg holds:
  - command codes: CMD_WR=8'hAA, CMD_RD=8'hBB, CMD_ALU_OP=8'hCC, CMD_ALU_NOP=8'hDD
  - operand addresses: ADDR_OP_A=0, ADDR_OP_B=1
  - the state enum type
- Single module, no sub-modules.

## Test plan
- Write: AA, 05, 3C -> one WrEn pulse with Address=5 and WrData=0x3C. No FIFO push.
- Read: BB, 05, then RdData=0x3C with RdData_Valid -> RdEn pulse with Address=5, then one WR_INC with WR_DATA=0x3C.
- ALU with operands: CC, 12, 34, 00, then ALU_OUT=0x0046 with OUT_Valid -> WrEn at addr 0 (0x12) and addr 1 (0x34), ALU_FUN=0, CLK_EN high, then pushes 0x46 then 0x00.
- FIFO back-pressure: ALU result 0xABCD with FIFO_FULL=1 for 5 cycles -> no WR_INC during the stall, then 0xCD, 0xAB pushed on consecutive cycles.
- Garbage and abort: bytes 0x55 in IDLE -> no strobes. Reset pulse after AA, 07 -> no WrEn, and a following BB, 07 frame works normally.
